mem_port_arbiter: RTL and testbench

//  Shares one cache-side AXIMaster (line read/write command interface) between NUM_REQ line requesters:

---
 rtl/mem_port_arbiter.sv | 133 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares the cache-side AXI line master between NUM_REQ requesters, one transaction at a time.
// Build option: define ARB_WB_PRIORITY_EN to give write-back port 0 absolute priority over the round-robin ports.
module mem_port_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int ADDR_W  = 32,
  parameter int LINE_W  = 256,
  parameter int WORD_W  = 32
) (
  input  logic                        Clk,
  input  logic                        NotRst,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ-1:0]          req_rw,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
  input  logic [NUM_REQ*LINE_W-1:0]   req_wline,
  output logic [NUM_REQ-1:0]          req_grant,
  output logic [NUM_REQ-1:0]          req_done,
  output logic [NUM_REQ-1:0]          req_rvalid,
  output logic [WORD_W-1:0]           req_rdata,
  output logic [ADDR_W-1:0]           axi_addr,
  output logic [LINE_W-1:0]           axi_wdata,
  output logic                        axi_start_read,
  output logic                        axi_start_write,
  input  logic [WORD_W-1:0]           axi_rdata,
  input  logic                        axi_rvalid,
  input  logic                        axi_read_done,
  input  logic                        axi_write_done
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_e;

  state_e             state_q;
  logic [NUM_REQ-1:0] grant_q, done_q;
  logic [IDX_W-1:0]   owner_q, rr_q, rr_d;
  logic               rw_q, start_rd_q, start_wr_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [LINE_W-1:0]  wline_q;

  logic [NUM_REQ-1:0] elig;
  logic [IDX_W-1:0]   cand, win_idx;
  logic               win_found;
  logic               xfer_end, rd_window;

  // Rotating search starting just past the last owner; first eligible port wins.
  always_comb begin
    elig      = req_valid;
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
`ifdef ARB_WB_PRIORITY_EN
    elig[0] = 1'b0;
`endif
    for (int off = 1; off <= NUM_REQ; off++) begin
      cand = IDX_W'((int'(rr_q) + off) % NUM_REQ);
      if (!win_found && elig[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
`ifdef ARB_WB_PRIORITY_EN
    if (req_valid[0]) begin
      win_found = 1'b1;
      win_idx   = '0;
    end
`endif
  end

`ifdef ARB_WB_PRIORITY_EN
  // Write-back grants must not disturb the rotation among the other ports.
  assign rr_d = (owner_q == '0) ? rr_q : owner_q;
`else
  assign rr_d = owner_q;
`endif

  assign xfer_end  = rw_q ? axi_write_done : axi_read_done;
  assign rd_window = (state_q == WAIT) && !rw_q;

  always_ff @(posedge Clk or negedge NotRst) begin
    if (!NotRst) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      done_q     <= '0;
      owner_q    <= '0;
      rr_q       <= IDX_W'(NUM_REQ - 1);
      rw_q       <= 1'b0;
      start_rd_q <= 1'b0;
      start_wr_q <= 1'b0;
      addr_q     <= '0;
      wline_q    <= '0;
    end else begin
      start_rd_q <= 1'b0;
      start_wr_q <= 1'b0;
      done_q     <= '0;
      unique case (state_q)
        IDLE: if (win_found) begin
          state_q    <= ISSUE;
          owner_q    <= win_idx;
          grant_q    <= NUM_REQ'(1) << win_idx;
          rw_q       <= req_rw[win_idx];
          addr_q     <= req_addr[win_idx*ADDR_W +: ADDR_W];
          wline_q    <= req_wline[win_idx*LINE_W +: LINE_W];
          start_rd_q <= ~req_rw[win_idx];
          start_wr_q <= req_rw[win_idx];
        end
        ISSUE: state_q <= WAIT;
        WAIT: if (xfer_end) begin
          state_q <= DONE;
          done_q  <= grant_q;
        end
        DONE: begin
          state_q <= IDLE;
          grant_q <= '0;
          rr_q    <= rr_d;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_lane
    assign req_rvalid[g] = grant_q[g] & rd_window & axi_rvalid;
  end

  assign req_grant       = grant_q;
  assign req_done        = done_q;
  assign req_rdata       = axi_rdata;
  assign axi_addr        = addr_q;
  assign axi_wdata       = wline_q;
  assign axi_start_read  = start_rd_q;
  assign axi_start_write = start_wr_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: vector table for a single line read, hand sequences for the rest.
module tb_mem_port_arbiter;
  localparam int NUM_REQ = 3;
  localparam int ADDR_W  = 32;
  localparam int LINE_W  = 256;
  localparam int WORD_W  = 32;

  logic                       Clk = 1'b0;
  logic                       NotRst;
  logic [NUM_REQ-1:0]         req_valid, req_rw;
  logic [NUM_REQ*ADDR_W-1:0]  req_addr;
  logic [NUM_REQ*LINE_W-1:0]  req_wline;
  logic [NUM_REQ-1:0]         req_grant, req_done, req_rvalid;
  logic [WORD_W-1:0]          req_rdata, axi_rdata;
  logic [ADDR_W-1:0]          axi_addr;
  logic [LINE_W-1:0]          axi_wdata;
  logic                       axi_start_read, axi_start_write;
  logic                       axi_rvalid, axi_read_done, axi_write_done;

  int checks = 0;
  int errors = 0;

  mem_port_arbiter #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .LINE_W(LINE_W), .WORD_W(WORD_W)) dut (
    .Clk(Clk), .NotRst(NotRst),
    .req_valid(req_valid), .req_rw(req_rw), .req_addr(req_addr), .req_wline(req_wline),
    .req_grant(req_grant), .req_done(req_done), .req_rvalid(req_rvalid), .req_rdata(req_rdata),
    .axi_addr(axi_addr), .axi_wdata(axi_wdata),
    .axi_start_read(axi_start_read), .axi_start_write(axi_start_write),
    .axi_rdata(axi_rdata), .axi_rvalid(axi_rvalid),
    .axi_read_done(axi_read_done), .axi_write_done(axi_write_done)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [2:0] valid;
    logic [2:0] rw;
    logic       arv;
    logic       rd;
    logic       wd;
    logic [2:0] grant;
    logic [2:0] done;
    logic [2:0] rvalid;
    logic       sr;
    logic       sw;
  } vec_t;

  localparam int NV = 15;
  vec_t tbl [NV];

  function automatic vec_t mk(input logic [2:0] v, input logic [2:0] rw, input logic arv, input logic rd,
                              input logic wd, input logic [2:0] g, input logic [2:0] d,
                              input logic [2:0] rv, input logic sr, input logic sw);
    vec_t r;
    r.valid = v; r.rw = rw; r.arv = arv; r.rd = rd; r.wd = wd;
    r.grant = g; r.done = d; r.rvalid = rv; r.sr = sr; r.sw = sw;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // One read transaction from ISSUE through the following IDLE cycle.
  task automatic serve(input logic [2:0] exp, input bit rereq, input string nm);
    @(negedge Clk); #1;
    chk({nm, " issue grant"}, req_grant, exp);
    chk({nm, " start_read"}, axi_start_read, 1'b1);
    @(negedge Clk); axi_read_done = 1'b1; #1;
    chk({nm, " wait grant"}, req_grant, exp);
    @(negedge Clk); axi_read_done = 1'b0; #1;
    chk({nm, " done"}, req_done, exp);
    @(negedge Clk); if (!rereq) req_valid = req_valid & ~exp; #1;
    chk({nm, " idle grant"}, req_grant, 3'b000);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = mk(3'b010, 3'b000, 0, 0, 0, 3'b000, 3'b000, 3'b000, 0, 0);
    tbl[1]  = mk(3'b010, 3'b000, 0, 0, 0, 3'b010, 3'b000, 3'b000, 1, 0);
    tbl[2]  = mk(3'b010, 3'b000, 1, 0, 0, 3'b010, 3'b000, 3'b010, 0, 0);
    tbl[3]  = mk(3'b010, 3'b000, 1, 0, 0, 3'b010, 3'b000, 3'b010, 0, 0);
    tbl[4]  = mk(3'b010, 3'b000, 0, 0, 0, 3'b010, 3'b000, 3'b000, 0, 0);
    for (int i = 5; i <= 10; i++)
      tbl[i] = mk(3'b010, 3'b000, 1, 0, 0, 3'b010, 3'b000, 3'b010, 0, 0);
    tbl[11] = mk(3'b010, 3'b000, 0, 0, 1, 3'b010, 3'b000, 3'b000, 0, 0);
    tbl[12] = mk(3'b010, 3'b000, 0, 1, 0, 3'b010, 3'b000, 3'b000, 0, 0);
    tbl[13] = mk(3'b010, 3'b000, 0, 0, 0, 3'b010, 3'b010, 3'b000, 0, 0);
    tbl[14] = mk(3'b000, 3'b000, 0, 0, 0, 3'b000, 3'b000, 3'b000, 0, 0);

    NotRst = 1'b0;
    req_valid = '0; req_rw = '0; req_addr = '0; req_wline = '0;
    axi_rdata = '0; axi_rvalid = 1'b1; axi_read_done = 1'b0; axi_write_done = 1'b0;
    req_addr[1*ADDR_W +: ADDR_W] = 32'h4000_0020;

    // Reset state
    repeat (2) @(negedge Clk);
    #1;
    chk("rst grant", req_grant, 3'b000);
    chk("rst done", req_done, 3'b000);
    chk("rst rvalid", req_rvalid, 3'b000);
    chk("rst starts", {axi_start_read, axi_start_write}, 2'b00);
    chk("rst addr", axi_addr, 32'h0);
    chk("rst wdata", axi_wdata, 256'h0);
    axi_rvalid = 1'b0;
    @(negedge Clk); NotRst = 1'b1;

    // Test 1: single read on port 1, 8 beats with one gap, stray write_done ignored
    for (int i = 0; i < NV; i++) begin
      @(negedge Clk);
      req_valid = tbl[i].valid; req_rw = tbl[i].rw; axi_rvalid = tbl[i].arv;
      axi_read_done = tbl[i].rd; axi_write_done = tbl[i].wd;
      axi_rdata = 32'h1000 + i;
      #1;
      chk($sformatf("vec%0d outs", i),
          {req_grant, req_done, req_rvalid, axi_start_read, axi_start_write},
          {tbl[i].grant, tbl[i].done, tbl[i].rvalid, tbl[i].sr, tbl[i].sw});
      if (tbl[i].sr) chk($sformatf("vec%0d addr", i), axi_addr, 32'h4000_0020);
      if (tbl[i].arv) chk($sformatf("vec%0d rdata", i), req_rdata, 32'h1000 + i);
    end

    // Test 2: single write on port 0 with latched address/line
    @(negedge Clk);
    req_valid = 3'b001; req_rw = 3'b001;
    req_addr[0 +: ADDR_W] = 32'h4000_0100;
    req_wline[0 +: LINE_W] = {8{32'hA5A5_A5A5}};
    #1; chk("wr idle grant", req_grant, 3'b000);
    @(negedge Clk);
    req_addr[0 +: ADDR_W] = 32'hDEAD_0000; req_wline[0 +: LINE_W] = '0;
    #1;
    chk("wr issue grant", req_grant, 3'b001);
    chk("wr starts", {axi_start_read, axi_start_write}, 2'b01);
    chk("wr addr", axi_addr, 32'h4000_0100);
    chk("wr wdata", axi_wdata, {8{32'hA5A5_A5A5}});
    @(negedge Clk); axi_rvalid = 1'b1; axi_read_done = 1'b1; #1;
    chk("wr no rvalid", req_rvalid, 3'b000);
    chk("wr starts low", {axi_start_read, axi_start_write}, 2'b00);
    @(negedge Clk); axi_rvalid = 1'b0; axi_read_done = 1'b0; axi_write_done = 1'b1; #1;
    chk("wr stray rd ignored", {req_grant, req_done}, {3'b001, 3'b000});
    chk("wr addr held", axi_addr, 32'h4000_0100);
    @(negedge Clk); axi_write_done = 1'b0; #1;
    chk("wr done", req_done, 3'b001);
    @(negedge Clk); req_valid = 3'b000; req_rw = 3'b000; #1;
    chk("wr idle after", {req_grant, req_done}, 6'b0);

    // Test 5: port 2 read, stray write_done in WAIT
    @(negedge Clk);
    req_valid = 3'b100; req_addr[2*ADDR_W +: ADDR_W] = 32'h4000_0300; #1;
    chk("t5 idle", req_grant, 3'b000);
    @(negedge Clk); #1;
    chk("t5 issue", {req_grant, axi_start_read}, {3'b100, 1'b1});
    chk("t5 addr", axi_addr, 32'h4000_0300);
    @(negedge Clk); axi_write_done = 1'b1; #1;
    chk("t5 wait grant", req_grant, 3'b100);
    @(negedge Clk); axi_write_done = 1'b0; axi_rvalid = 1'b1; #1;
    chk("t5 no done", {req_grant, req_done}, {3'b100, 3'b000});
    chk("t5 rvalid", req_rvalid, 3'b100);
    @(negedge Clk); axi_rvalid = 1'b0; axi_read_done = 1'b1; #1;
    chk("t5 still wait", req_done, 3'b000);
    @(negedge Clk); axi_read_done = 1'b0; #1;
    chk("t5 done", req_done, 3'b100);
    @(negedge Clk); req_valid = 3'b000; #1;
    chk("t5 idle after", req_grant, 3'b000);

    // Test 4: ports 1,2 pending, port 0 raises during port 1 WAIT
    @(negedge Clk); req_valid = 3'b110; #1;
    chk("t4 idle", req_grant, 3'b000);
    @(negedge Clk); #1;
    chk("t4 issue p1", {req_grant, axi_start_read}, {3'b010, 1'b1});
    @(negedge Clk); req_valid = 3'b111; axi_read_done = 1'b1; #1;
    chk("t4 wait p1", req_grant, 3'b010);
    @(negedge Clk); axi_read_done = 1'b0; #1;
    chk("t4 done p1", req_done, 3'b010);
    @(negedge Clk); req_valid = 3'b101; #1;
    chk("t4 idle p1", req_grant, 3'b000);
`ifdef ARB_WB_PRIORITY_EN
    serve(3'b001, 1'b0, "t4 first");
    serve(3'b100, 1'b0, "t4 second");
`else
    serve(3'b100, 1'b0, "t4 first");
    serve(3'b001, 1'b0, "t4 second");
`endif

    // Test 3: all three valid at reset release
    @(negedge Clk); NotRst = 1'b0; req_valid = 3'b111; req_rw = 3'b000;
    @(negedge Clk); NotRst = 1'b1; #1;
    chk("t3 idle", req_grant, 3'b000);
`ifdef ARB_WB_PRIORITY_EN
    serve(3'b001, 1'b0, "t3 g0");
    serve(3'b010, 1'b1, "t3 g1");
    serve(3'b100, 1'b1, "t3 g2");
    serve(3'b010, 1'b1, "t3 g3");
`else
    serve(3'b001, 1'b1, "t3 g0");
    serve(3'b010, 1'b1, "t3 g1");
    serve(3'b100, 1'b1, "t3 g2");
    serve(3'b001, 1'b1, "t3 g3");
`endif

    // Test 6: reset in WAIT abandons the transaction; port 1 re-granted afresh
    @(negedge Clk); #3; NotRst = 1'b0; req_valid = 3'b010;
    @(negedge Clk); NotRst = 1'b1; #1;
    chk("t6 idle", req_grant, 3'b000);
    @(negedge Clk); #1;
    chk("t6 issue", {req_grant, axi_start_read}, {3'b010, 1'b1});
    @(negedge Clk); axi_rvalid = 1'b1; #1;
    chk("t6 wait rvalid", req_rvalid, 3'b010);
    #2; NotRst = 1'b0; #1;
    chk("t6 async ctl", {req_grant, req_done, req_rvalid, axi_start_read, axi_start_write}, 11'b0);
    chk("t6 async addr", axi_addr, 32'h0);
    chk("t6 async wdata", axi_wdata, 256'h0);
    @(negedge Clk); axi_rvalid = 1'b0; #1;
    chk("t6 no done", req_done, 3'b000);
    @(negedge Clk); NotRst = 1'b1; #1;
    chk("t6 rel idle", req_grant, 3'b000);
    @(negedge Clk); #1;
    chk("t6 regrant", {req_grant, axi_start_read}, {3'b010, 1'b1});
    chk("t6 regrant addr", axi_addr, 32'h4000_0020);
    @(negedge Clk); axi_read_done = 1'b1;
    @(negedge Clk); axi_read_done = 1'b0; #1;
    chk("t6 done", req_done, 3'b010);
    @(negedge Clk); req_valid = 3'b000;

    repeat (2) @(negedge Clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
